// File: rtl/mlp_pio_in_edge.sv
// Avalon-MM input PIO: synchronises board inputs, optionally debounces them,
// captures per-bit edges in a write-1-to-clear register and raises a masked
// level interrupt toward the Nios II.
module mlp_pio_in_edge #(
  parameter int WIDTH           = 10,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irq_mask;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the second stage would see sync1's new value in the same edge.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync2;
    end else begin : g_debounce
      logic [CW-1:0] cnt [WIDTH];

      // Accept a new level only after it has persisted for DEBOUNCE_CYCLES.
      always_ff @(posedge clk) begin
        // NOTE: the per-bit counter array is reset explicitly so that a reset
        // arriving mid-debounce discards any partial count.
        if (reset) begin
          stable <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
              stable[i] <= sync2[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

  // Select which transitions count as an edge; 3 behaves like "any".
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch.
    edges = '0;
    if (EDGE_TYPE == 0)      edges = stable & ~prev;
    else if (EDGE_TYPE == 1) edges = ~stable & prev;
    else                     edges = (stable & ~prev) | (~stable & prev);
  end

  // Edge history, capture register (set beats clear) and interrupt mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= '0;
      edgecapture <= '0;
      irq_mask    <= '0;
    end else begin
      prev        <= stable;
      edgecapture <= (edgecapture & ~clr) | edges;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edgecapture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irq_mask);

endmodule

// File: tb/tb_mlp_pio_in_edge.sv
// Self-checking bench: instance a is bypass / rising edge, instance b is
// debounced (4 cycles) / any edge. Both share clock, reset and bus.
module tb_mlp_pio_in_edge;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_a;
  logic [9:0]  in_b;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  int n_cmp = 0;
  int n_err = 0;

  mlp_pio_in_edge #(.WIDTH(10), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a)
  );

  mlp_pio_in_edge #(.WIDTH(10), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input bit sel_b, input logic [1:0] a,
                    input logic [31:0] exp);
    address = a;
    #1;
    check(tag, sel_b ? rd_b : rd_a, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Reference model state for the randomized phase on instance a.
  logic [9:0] hist[$];
  logic [9:0] m_ec, m_mask, m_rise, m_clr, m_data;
  logic [31:0] m_exp;
  bit         do_wr;
  logic [31:0] seen;

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_a = '0; in_b = '0;

    // ---- reset values ----
    repeat (3) step();
    rd("rst_data", 0, 2'd0, 32'h0);
    rd("rst_rsvd", 0, 2'd1, 32'h0);
    rd("rst_mask", 0, 2'd2, 32'h0);
    rd("rst_ec",   0, 2'd3, 32'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);

    // ---- input held high through reset gives a rising edge after release ----
    in_a = 10'h001;
    repeat (3) step();
    reset = 1'b0;
    step();                                     // edge k: sync1 = 1
    step();                                     // k+1: data = 1
    rd("rst_hold_data", 0, 2'd0, 32'h001);
    rd("rst_hold_ec0",  0, 2'd3, 32'h000);
    step();                                     // k+2: captured
    rd("rst_hold_ec1",  0, 2'd3, 32'h001);
    in_a = 10'h000;
    wr(2'd3, 32'h3FF);
    repeat (3) step();
    rd("init_clear", 0, 2'd3, 32'h000);

    // ---- rising capture, bypass ----
    wr(2'd2, 32'h3FF);
    in_a = 10'h204;
    step();                                     // k
    rd("rise_data_k", 0, 2'd0, 32'h000);
    step();                                     // k+1
    rd("rise_data_k1", 0, 2'd0, 32'h204);
    rd("rise_ec_k1",   0, 2'd3, 32'h000);
    check("rise_irq_k1", {31'h0, irq_a}, 32'h0);
    step();                                     // k+2
    rd("rise_ec_k2", 0, 2'd3, 32'h204);
    check("rise_irq_k2", {31'h0, irq_a}, 32'h1);
    in_a = 10'h000;
    repeat (4) step();
    rd("fall_no_capture", 0, 2'd3, 32'h204);

    // ---- write-1-to-clear race: set wins ----
    in_a = 10'h004;
    step();                                     // k
    step();                                     // k+1
    wr(2'd3, 32'h004);                          // k+2: clear and new edge together
    rd("race_ec", 0, 2'd3, 32'h204);
    check("race_irq", {31'h0, irq_a}, 32'h1);
    in_a = 10'h000;
    repeat (3) step();
    wr(2'd3, 32'h204);
    rd("quiet_clear_ec", 0, 2'd3, 32'h000);
    check("quiet_clear_irq", {31'h0, irq_a}, 32'h0);

    // ---- mask gating ----
    wr(2'd2, 32'h002);
    in_a = 10'h001;
    repeat (3) step();
    rd("mask_ec", 0, 2'd3, 32'h001);
    check("mask_irq_off", {31'h0, irq_a}, 32'h0);
    wr(2'd2, 32'h001);
    check("mask_irq_on", {31'h0, irq_a}, 32'h1);
    rd("mask_read", 0, 2'd2, 32'h001);
    rd("rsvd_read", 0, 2'd1, 32'h000);
    wr(2'd1, 32'hFFFF_FFFF);
    rd("rsvd_after_wr", 0, 2'd1, 32'h000);

    // ---- randomized traffic against the reference model ----
    reset = 1'b1; in_a = '0;
    repeat (2) step();
    reset = 1'b0;
    hist = '{10'h0, 10'h0, 10'h0};  // samples at the last three edges
    m_ec = '0; m_mask = '0;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) in_a = 10'($urandom);
      address    = 2'($urandom);
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      do_wr      = chipselect && !write_n;
      // data seen before this edge is the sample from two edges back;
      // the edge detector compares it with the sample three edges back
      m_rise = hist[hist.size()-2] & ~hist[hist.size()-3];
      m_clr  = (do_wr && address == 2'd3) ? writedata[9:0] : 10'h0;
      m_ec   = (m_ec & ~m_clr) | m_rise;
      if (do_wr && address == 2'd2) m_mask = writedata[9:0];
      hist.push_back(in_a);
      void'(hist.pop_front());
      step();
      m_data = hist[hist.size()-2];
      case (address)
        2'd0:    m_exp = {22'h0, m_data};
        2'd2:    m_exp = {22'h0, m_mask};
        2'd3:    m_exp = {22'h0, m_ec};
        default: m_exp = 32'h0;
      endcase
      check("rand_read", rd_a, m_exp);
      check("rand_irq", {31'h0, irq_a}, {31'h0, |(m_ec & m_mask)});
    end
    chipselect = 1'b0; write_n = 1'b1;

    // ---- debounce D=4, any edge (instance b) ----
    reset = 1'b1; in_a = '0; in_b = '0;
    repeat (2) step();
    reset = 1'b0;
    address = 2'd0;
    step();
    seen = '0;
    in_b = 10'h001;
    repeat (3) begin step(); seen |= rd_b; end   // 3-cycle glitch
    in_b = 10'h000;
    repeat (10) begin step(); seen |= rd_b; end
    check("glitch_data", seen, 32'h0);
    rd("glitch_ec", 1, 2'd3, 32'h0);

    address = 2'd0;
    in_b = 10'h001;
    step();                                     // k
    repeat (4) step();                          // k+4
    rd("db_data_k4", 1, 2'd0, 32'h000);
    step();                                     // k+5
    rd("db_data_k5", 1, 2'd0, 32'h001);
    rd("db_ec_k5",   1, 2'd3, 32'h000);
    step();                                     // k+6
    rd("db_ec_k6",   1, 2'd3, 32'h001);
    check("db_irq_masked", {31'h0, irq_b}, 32'h0);
    wr(2'd3, 32'h001);                          // k+7
    rd("db_clear", 1, 2'd3, 32'h000);
    step();                                     // k+8
    step();                                     // k+9: last high sample
    in_b = 10'h000;
    repeat (5) step();                          // k+14
    rd("db_fall_data_k14", 1, 2'd0, 32'h001);
    step();                                     // k+15
    rd("db_fall_data_k15", 1, 2'd0, 32'h000);
    rd("db_fall_ec_k15",   1, 2'd3, 32'h000);
    step();                                     // k+16
    rd("db_fall_ec_k16",   1, 2'd3, 32'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
